tiny16_uart_tx: RTL and testbench
=================================

# tiny16_uart_tx

Serial transmitter for the tiny16 output port. It consumes the byte strobed on the CPU's `OUT`/`OUT_EN` pair and buffers it in a small FIFO. It then shifts the byte out as an asynchronous 8N1 UART frame on a single pin. It sits between the `tiny16` core and the board TX pin, as the consuming end of the CPU output interface.

## Interface
- `CLKS_PER_BIT`, 139, clock cycles per serial bit (16 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 8, byte entries buffered; power of two, ≥ 2.

- `CLK`  input  1  system clock; all logic on its rising edge.
- `RST`  input  1  reset: synchronous, active-high; one cycle is sufficient.
- `DATA`  input  8  byte from CPU `OUT`.
- `DATA_EN`  input  1  one-cycle write strobe from CPU `OUT_EN`.
- `TX`  output  1  serial line, idle high.
- `BUSY`  output  1  high while a frame is on the line or the FIFO is non-empty.
- `FULL`  output  1  FIFO holds `FIFO_DEPTH` bytes.
- `EMPTY`  output  1  FIFO holds 0 bytes.
- `OVERRUN`  output  1  sticky; a write was dropped because the FIFO was full.

## Operation
- FIFO: registered read and write pointers, each `log2(FIFO_DEPTH)` bits, plus a count of `log2(FIFO_DEPTH)+1` bits. Pointers wrap modulo `FIFO_DEPTH`.
- Write:
  - `DATA_EN` high with count < `FIFO_DEPTH` stores `DATA` at the write pointer.
  - `DATA_EN` high with count == `FIFO_DEPTH` drops the byte and sets `OVERRUN`. This holds even if a pop occurs in the same cycle.
- Simultaneous accepted write and pop: count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
  - IDLE: `TX`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counters, and go to START.
  - START: `TX`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `TX`=shift[0], LSB first. Shift right every `CLKS_PER_BIT` cycles. After 8 bits, go to PARITY if the macro is defined, otherwise STOP.
  - PARITY: `TX`=even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `TX`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle bit; otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary. Width is `$clog2(CLKS_PER_BIT)`.
- `TX` is driven from a flop, so the line is glitch-free.
- `BUSY` = (state != IDLE) | !EMPTY.
- `OVERRUN` clears only on `RST`.
- Reset mid-frame: the frame is abandoned, the FIFO is flushed, and `TX` returns to 1 on the cycle after the reset edge. No partial stop bit is emitted.
- `DATA_EN` asserted during `RST` is ignored.

## Timing
- Reset values: `TX`=1, `BUSY`=0, `FULL`=0, `EMPTY`=1, `OVERRUN`=0; state=IDLE; pointers and count = 0.
- Write at edge N with the FSM in IDLE:
  - `EMPTY` falls after edge N.
  - Pop at edge N+1, and `TX` falls after edge N+1.
  - Net latency: one cycle from the strobe edge to the start bit.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `FULL`, `EMPTY` and `OVERRUN` are registered and update on the cycle after the causing edge.
- There is no back-pressure to the CPU. Software must poll `FULL` or pace its writes.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state exists and the frame is 8E1 (11 bits).
  - The parity bit is the XOR of the data byte, so the number of ones across data and parity is even.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic; the frame is 8N1 (10 bits).
  - Output is cycle-identical to the parity build minus the parity bit period.

## Test plan
Bench uses `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4; sample `TX` mid-bit.
- Reset and idle: hold `RST` for 4 cycles, release, wait 20 cycles -> `TX`=1, `BUSY`=0, `EMPTY`=1, `FULL`=0, `OVERRUN`=0 throughout.
- Single byte: strobe `DATA`=0x55 -> `TX` falls one cycle after the strobe edge; bits decode to 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop); 40 cycles long; `BUSY` drops after the stop bit.
- Back-to-back: strobe 0x01, 0x80, 0xFF on consecutive cycles -> three contiguous frames (120 cycles, no idle gap); bytes decode in order; `EMPTY` rises when the third byte pops.
- Overrun: with a frame in progress, strobe 5 bytes 0xA0..0xA4 on consecutive cycles -> `FULL`=1 after the 4th byte that stays queued; the excess byte is dropped; `OVERRUN`=1 and stays set; the queued bytes are transmitted in order.
- Reset mid-frame: `RST` during data bit 3 of 0x3C -> `TX`=1 the next cycle; FIFO empty; no further frame; a later strobe of 0x12 transmits cleanly.
- Parity build (`UART_TX_PARITY_EN`): send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; each frame is 44 cycles.

Source files
------------

// File: rtl/tiny16_uart_tx.sv
// tiny16 output-port UART transmitter: FIFO-buffered 8N1 (8E1 with UART_TX_PARITY_EN); start bit one cycle after the write strobe.
// No back-pressure: writes into a full FIFO are dropped and latch the sticky OVERRUN flag.
module tiny16_uart_tx #(
    parameter int CLKS_PER_BIT = 139,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA,
    input  logic       DATA_EN,
    output logic       TX,
    output logic       BUSY,
    output logic       FULL,
    output logic       EMPTY,
    output logic       OVERRUN
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    state_t            state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
`ifdef UART_TX_PARITY_EN
    logic              parity;
`endif

    logic              bit_end;
    logic              fifo_has;
    logic              pop;
    logic              push;
    logic              drop;
    logic [7:0]        head;

    always_comb begin
        bit_end   = (baud == BAUD_LAST);
        fifo_has  = (count != '0);
        // IDLE pops immediately; STOP pops on its last cycle so frames abut
        pop       = fifo_has && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
        push      = DATA_EN && (count != DEPTH_C);
        drop      = DATA_EN && (count == DEPTH_C);
        head      = mem[rd_ptr];
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            FULL    <= 1'b0;
            EMPTY   <= 1'b1;
            OVERRUN <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            FULL  <= (count_nxt == DEPTH_C);
            EMPTY <= (count_nxt == '0);
            if (drop) begin
                OVERRUN <= 1'b1;
            end
        end
    end

    // Storage has no reset; a reset only moves the pointers
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem[wr_ptr] <= DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            TX      <= 1'b1;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    TX   <= 1'b1;
                    baud <= '0;
                    if (pop) begin
                        shift   <= head;
                        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        parity  <= ^head;
`endif
                        state   <= S_START;
                        TX      <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= S_DATA;
                        TX    <= shift[0];
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            TX    <= parity;
`else
                            state <= S_STOP;
                            TX    <= 1'b1;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            TX      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= S_STOP;
                        TX    <= 1'b1;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (pop) begin
                            shift   <= head;
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            parity  <= ^head;
`endif
                            state   <= S_START;
                            TX      <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            TX    <= 1'b1;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    TX    <= 1'b1;
                    baud  <= '0;
                end
            endcase
        end
    end

    assign BUSY = (state != S_IDLE) || !EMPTY;

endmodule

// File: tb/tb_tiny16_uart_tx.sv
// Bench for tiny16_uart_tx: directed strobes feed an expected-byte queue; a line monitor decodes frames and compares.
`timescale 1ns/1ps
module tb_tiny16_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;
    localparam logic [31:0] ONES = (32'd1 << CPB) - 32'd1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DATA = 8'h00;
    logic       DATA_EN = 1'b0;
    logic       TX, BUSY, FULL, EMPTY, OVERRUN;

    int errors = 0;
    int checks = 0;
    int mcyc = 0;
    int mark = 0;
    logic [7:0] sb[$];
    int start_q[$];

    tiny16_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .DATA(DATA), .DATA_EN(DATA_EN),
        .TX(TX), .BUSY(BUSY), .FULL(FULL), .EMPTY(EMPTY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        DATA    = b;
        DATA_EN = 1'b1;
        @(posedge CLK);
        #1;
        DATA_EN = 1'b0;
        mark    = mcyc;
    endtask

    task automatic strobe_exp(input logic [7:0] b);
        sb.push_back(b);
        strobe(b);
    endtask

    // Line monitor: one sample per cycle on the falling clock edge
    initial begin : monitor
        logic [FRAME_CYC-1:0] s;
        logic [7:0] got;
        logic [7:0] exp_b;
        int  st;
        bit  ab;
        forever begin
            @(negedge CLK);
            mcyc++;
            if (RST === 1'b0 && TX === 1'b0) begin
                st   = mcyc;
                s    = '0;
                s[0] = TX;
                ab   = 1'b0;
                for (int i = 1; i < FRAME_CYC; i++) begin
                    @(negedge CLK);
                    mcyc++;
                    if (RST !== 1'b0) ab = 1'b1;
                    s[i] = TX;
                end
                if (!ab) begin
                    start_q.push_back(st);
                    for (int k = 0; k < 8; k++) got[k] = s[CPB + k*CPB + CPB/2];
                    chk("start_bit", 32'(s[CPB-1:0]), 32'd0);
                    chk("stop_bit", 32'(s[FRAME_CYC-1 -: CPB]), ONES);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got byte %02h, expected no frame", got);
                    end else begin
                        exp_b = sb.pop_front();
                        chk("frame_byte", 32'(got), 32'(exp_b));
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", 32'(s[9*CPB + CPB/2]), 32'(^exp_b));
`endif
                    end
                end
            end
        end
    end

    initial begin
        // Reset and idle
        RST = 1'b1;
        tick(4);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle_tx", 32'(TX), 32'd1);
            chk("idle_busy", 32'(BUSY), 32'd0);
            chk("idle_empty", 32'(EMPTY), 32'd1);
            chk("idle_full", 32'(FULL), 32'd0);
            chk("idle_overrun", 32'(OVERRUN), 32'd0);
        end

        // Single byte 0x55
        start_q.delete();
        strobe_exp(8'h55);
        chk("single_empty_fall", 32'(EMPTY), 32'd0);
        chk("single_busy", 32'(BUSY), 32'd1);
        tick(FRAME_CYC);
        chk("single_busy_last_stop", 32'(BUSY), 32'd1);
        chk("single_tx_stop", 32'(TX), 32'd1);
        tick(1);
        chk("single_busy_drop", 32'(BUSY), 32'd0);
        chk("single_empty", 32'(EMPTY), 32'd1);
        chk("single_frames", 32'(start_q.size()), 32'd1);
        if (start_q.size() > 0) chk("single_latency", 32'(start_q[0]), 32'(mark + 2));
        chk("single_drained", 32'(sb.size()), 32'd0);

        // Back-to-back 0x01, 0x80, 0xFF
        start_q.delete();
        strobe_exp(8'h01);
        strobe_exp(8'h80);
        strobe_exp(8'hFF);
        tick(2*FRAME_CYC - 2);
        chk("b2b_empty_before_pop3", 32'(EMPTY), 32'd0);
        tick(1);
        chk("b2b_empty_after_pop3", 32'(EMPTY), 32'd1);
        tick(FRAME_CYC);
        chk("b2b_busy_end", 32'(BUSY), 32'd0);
        chk("b2b_drained", 32'(sb.size()), 32'd0);
        chk("b2b_frames", 32'(start_q.size()), 32'd3);
        if (start_q.size() == 3) begin
            chk("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'(FRAME_CYC));
            chk("b2b_gap2", 32'(start_q[2] - start_q[1]), 32'(FRAME_CYC));
        end

        // Overrun: frame in flight, five strobes into a four-entry FIFO
        strobe_exp(8'h99);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) strobe_exp(8'hA0 + 8'(i));
            else       strobe(8'hA0 + 8'(i));
            if (i == 2) chk("ovr_not_full", 32'(FULL), 32'd0);
            if (i == 3) begin
                chk("ovr_full", 32'(FULL), 32'd1);
                chk("ovr_flag_clear", 32'(OVERRUN), 32'd0);
            end
            if (i == 4) begin
                chk("ovr_flag_set", 32'(OVERRUN), 32'd1);
                chk("ovr_still_full", 32'(FULL), 32'd1);
            end
        end
        tick(5*FRAME_CYC);
        chk("ovr_drained", 32'(sb.size()), 32'd0);
        chk("ovr_sticky", 32'(OVERRUN), 32'd1);
        chk("ovr_full_end", 32'(FULL), 32'd0);
        chk("ovr_busy_end", 32'(BUSY), 32'd0);

        // Reset during data bit 3 of 0x3C with 0x77 queued; strobe during reset ignored
        strobe(8'h3C);
        strobe(8'h77);
        tick(17);
        chk("rst_pre_bit3", 32'(TX), 32'd1);
        chk("rst_pre_queued", 32'(EMPTY), 32'd0);
        RST     = 1'b1;
        DATA    = 8'h66;
        DATA_EN = 1'b1;
        tick(1);
        RST     = 1'b0;
        DATA_EN = 1'b0;
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_overrun", 32'(OVERRUN), 32'd0);
        chk("rst_full", 32'(FULL), 32'd0);
        for (int i = 0; i < 60; i++) begin
            tick(1);
            chk("rst_line_quiet", 32'(TX), 32'd1);
        end
        strobe_exp(8'h12);
        tick(FRAME_CYC + 2);
        chk("rst_after_drained", 32'(sb.size()), 32'd0);
        chk("rst_after_busy", 32'(BUSY), 32'd0);

        // 0x07 then 0x03 back-to-back (parity 1 then 0 in the parity build)
        start_q.delete();
        strobe_exp(8'h07);
        strobe_exp(8'h03);
        tick(2*FRAME_CYC + 2);
        chk("par_drained", 32'(sb.size()), 32'd0);
        chk("par_frames", 32'(start_q.size()), 32'd2);
        if (start_q.size() == 2) chk("par_frame_len", 32'(start_q[1] - start_q[0]), 32'(FRAME_CYC));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
